// File: rtl/data_mem_slave_if.sv
// data_mem_slave_if: data-side bus between the multicycle core and its memory slave.
//   MREQ    request (level)          WRITE   1 = store, 0 = load
//   SIZE    00 byte, 01 half, 1x word DAD     byte address
//   DDT_in  store data, right-aligned DDT_out load data, right-aligned
//   DDT_oe  load data valid/driven   ACKD_n  one-cycle active-low acknowledge
//   ERR     misaligned-access flag, valid with ACKD_n low
interface data_mem_slave_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic [31:0] DDT_in;
  logic [31:0] DDT_out;
  logic        DDT_oe;
  logic        ACKD_n;
  logic        ERR;

  modport master (
    output MREQ, WRITE, SIZE, DAD, DDT_in,
    input  DDT_out, DDT_oe, ACKD_n, ERR
  );

  modport slave (
    input  MREQ, WRITE, SIZE, DAD, DDT_in,
    output DDT_out, DDT_oe, ACKD_n, ERR
  );
endinterface

// File: rtl/data_mem_slave.sv
// data_mem_slave: word-organized RAM serving byte/half/word accesses from the
// core data bus after WAIT wait states, answering with a one-cycle ACKD_n pulse.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (RAM contents are kept)
//   bus  data_mem_slave_if slave modport (request, store data, load data, ack, error)
module data_mem_slave #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_slave_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BA_W  = ADDR_W + 2;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAITST, ACK, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack_n_q, ack_n_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              misaligned;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_masked;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic              we;

  // Decode of the captured access
  assign word_idx   = addr_q[BA_W-1:2];
  assign lane       = addr_q[1:0];
  assign misaligned = ((size_q == 2'b01) && lane[0]) ||
                      (size_q[1] && (lane != 2'b00));
  assign rd_word    = mem[word_idx];
  assign rd_shift   = rd_word >> {lane, 3'b000};

  // Load alignment and size masking; sign extension is left to the core
  always_comb begin
    case (size_q)
      2'b00:   rd_masked = {24'h0, rd_shift[7:0]};
      2'b01:   rd_masked = {16'h0, rd_shift[15:0]};
      default: rd_masked = rd_shift;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  // Commit only on the ACK cycle, never for errors or when reset aborts
  assign we = (state_q == ACK) && write_q && !misaligned && !rst;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    ack_n_d = 1'b1;
    oe_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.MREQ) begin
          addr_d  = bus.DAD[BA_W-1:0];
          write_d = bus.WRITE;
          size_d  = bus.SIZE;
          wdata_d = bus.DDT_in;
          if (WAIT == 0) begin
            state_d = ACK;
          end else begin
            cnt_d   = CNT_W'(WAIT - 1);
            state_d = WAITST;
          end
        end
      end
      WAITST: begin
        if (cnt_q == '0) state_d = ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACK: begin
        ack_n_d = 1'b0;
        err_d   = misaligned;
        if (!write_q) begin
          oe_d    = 1'b1;
          rdata_d = misaligned ? 32'h0 : rd_masked;
        end
        state_d = DONE;
      end
      DONE: begin
        // Wait for the request to drop so a held MREQ is serviced once
        if (!bus.MREQ) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      ack_n_q <= 1'b1;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      ack_n_q <= ack_n_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.ACKD_n  = ack_n_q;
  assign bus.DDT_oe  = oe_q;
  assign bus.ERR     = err_q;
  assign bus.DDT_out = rdata_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// tb_data_mem_slave: directed checks of data_mem_slave. Two instances share
// the same stimulus: u0 with WAIT=2 for most checks, u1 with WAIT=0 for the
// held-request check.
module tb_data_mem_slave;

  logic clk = 1'b0;
  logic rst;
  logic        mreq, wr;
  logic [1:0]  sz;
  logic [31:0] dad, din;
  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  data_mem_slave_if bus0();
  data_mem_slave_if bus1();

  assign bus0.MREQ = mreq;  assign bus1.MREQ = mreq;
  assign bus0.WRITE = wr;   assign bus1.WRITE = wr;
  assign bus0.SIZE = sz;    assign bus1.SIZE = sz;
  assign bus0.DAD = dad;    assign bus1.DAD = dad;
  assign bus0.DDT_in = din; assign bus1.DDT_in = din;

  data_mem_slave #(.ADDR_W(10), .WAIT(2)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_slave #(.ADDR_W(10), .WAIT(0)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access on u0, return ack latency (cycles after capture edge) and outputs.
  task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output logic oe, output logic ack_hi_after);
    @(negedge clk);
    mreq = 1'b1; wr = w; sz = s; dad = a; din = d;
    @(posedge clk);
    lat = -1; rd = 'x; er = 1'bx; oe = 1'bx; ack_hi_after = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus0.ACKD_n === 1'b0) begin
        lat = k; rd = bus0.DDT_out; er = bus0.ERR; oe = bus0.DDT_oe;
        break;
      end
    end
    @(negedge clk);
    ack_hi_after = bus0.ACKD_n;
    mreq = 1'b0; wr = 1'b0; din = 32'h0;
  endtask

  task automatic do_store(input string tag, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_err);
    int lat; logic [31:0] rd; logic er, oe, hi;
    access(1'b1, s, a, d, lat, rd, er, oe, hi);
    chk({tag, " lat"}, 32'(lat), 32'd3);
    chk({tag, " err"}, {31'h0, er}, {31'h0, exp_err});
    chk({tag, " oe"},  {31'h0, oe}, 32'h0);
    chk({tag, " ack1"}, {31'h0, hi}, 32'h1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_err);
    int lat; logic [31:0] rd; logic er, oe, hi;
    access(1'b0, s, a, 32'h0, lat, rd, er, oe, hi);
    chk({tag, " lat"},  32'(lat), 32'd3);
    chk({tag, " data"}, rd, exp_d);
    chk({tag, " err"},  {31'h0, er}, {31'h0, exp_err});
    if (!exp_err) chk({tag, " oe"}, {31'h0, oe}, 32'h1);
    chk({tag, " ack1"}, {31'h0, hi}, 32'h1);
  endtask

  initial begin
    int lat;
    int acks0, acks1;
    logic [31:0] rd;
    logic er, oe, hi;

    // Reset held two cycles with a pending request: nothing answers
    rst = 1'b1; mreq = 1'b1; wr = 1'b0; sz = 2'b10; dad = 32'h0; din = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst ackd_n", {31'h0, bus0.ACKD_n}, 32'h1);
      chk("rst oe",     {31'h0, bus0.DDT_oe}, 32'h0);
      chk("rst err",    {31'h0, bus0.ERR},    32'h0);
      chk("rst dout",   bus0.DDT_out,         32'h0);
    end
    rst = 1'b0;
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus0.ACKD_n === 1'b0) begin lat = k; break; end
    end
    chk("post-rst ack lat", 32'(lat), 32'd3);
    mreq = 1'b0;
    @(negedge clk);

    // Word store/load
    do_store("st w 10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    do_load ("ld w 10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte/half merge
    do_store("st w 20", 2'b10, 32'h20, 32'h0, 1'b0);
    do_store("st b 22", 2'b00, 32'h22, 32'h000000AB, 1'b0);
    do_store("st h 20", 2'b01, 32'h20, 32'h00001234, 1'b0);
    do_load ("ld w 20", 2'b10, 32'h20, 32'h00AB1234, 1'b0);
    do_load ("ld b 22", 2'b00, 32'h22, 32'h000000AB, 1'b0);
    do_load ("ld h 22", 2'b01, 32'h22, 32'h000000AB, 1'b0);
    do_load ("ld b 21", 2'b00, 32'h21, 32'h00000012, 1'b0);

    // Misaligned accesses
    do_store("st h 21 mis", 2'b01, 32'h21, 32'h0000FFFF, 1'b1);
    do_load ("ld w 20 kept", 2'b10, 32'h20, 32'h00AB1234, 1'b0);
    do_load ("ld w 22 mis", 2'b10, 32'h22, 32'h0, 1'b1);

    // Address wrap
    do_store("st w 1000", 2'b10, 32'h1000, 32'hCAFEF00D, 1'b0);
    do_load ("ld w 0 wrap", 2'b10, 32'h0, 32'hCAFEF00D, 1'b0);

    // Held request: exactly one ACK on each instance
    @(negedge clk);
    mreq = 1'b1; wr = 1'b0; sz = 2'b10; dad = 32'h0;
    acks0 = 0; acks1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus0.ACKD_n === 1'b0) acks0++;
      if (bus1.ACKD_n === 1'b0) acks1++;
    end
    chk("held acks wait0", 32'(acks1), 32'd1);
    chk("held acks wait2", 32'(acks0), 32'd1);
    mreq = 1'b0;
    @(negedge clk);

    // Reset during wait states aborts the store
    do_store("st w 40", 2'b10, 32'h40, 32'h11223344, 1'b0);
    @(negedge clk);
    mreq = 1'b1; wr = 1'b1; sz = 2'b10; dad = 32'h40; din = 32'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mreq = 1'b0;
    acks0 = 0;
    @(negedge clk);
    if (bus0.ACKD_n === 1'b0) acks0++;
    rst = 1'b0; wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus0.ACKD_n === 1'b0) acks0++;
    end
    chk("abort no ack", 32'(acks0), 32'd0);
    do_load("ld w 40 kept", 2'b10, 32'h40, 32'h11223344, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/data_mem_slave.md
# data_mem_slave

- Data-side memory slave attached directly downstream of the multicycle core's data bus. Consumes DAD, MREQ, WRITE, SIZE and write data.
- Performs byte, halfword and word accesses into an internal word-organized RAM after a fixed number of wait states.
- Answers each access with a one-cycle active-low ACKD_n pulse, and drives read data back toward DDT.

## Interface
- ADDR_W, 10: word-address width; RAM holds 2^ADDR_W 32-bit words.
- WAIT, 2: wait states between request capture and acknowledge (0..15).

Ports (the inout DDT is split at this boundary; the top-level tristate merges DDT_out/DDT_oe):
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MREQ  in  1  data access request, level.
- WRITE  in  1  1 = store, 0 = load; sampled with MREQ.
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- DAD  in  32  byte address; only bits [ADDR_W+1:0] are used.
- DDT_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- DDT_out  out  32  load data, right-aligned, upper bits zero.
- DDT_oe  out  1  high while load data is driven.
- ACKD_n  out  1  active-low acknowledge, one cycle per access.
- ERR  out  1  misaligned-access flag, valid with ACKD_n low.

## Operation
- States:
  - IDLE: capture DAD, WRITE, SIZE and DDT_in on the cycle MREQ=1 is seen.
    - WAIT=0 → ACK.
    - Otherwise load the counter with WAIT-1 → WAITST.
  - WAITST: decrement the counter; when the counter is 0 → ACK.
  - ACK: ACKD_n=0 for exactly one cycle; → DONE.
  - DONE: stay until MREQ=0, then → IDLE. A request held high across an ACK is never serviced twice.
- Inputs changing after capture are ignored until the block returns to IDLE.
- Word index = captured DAD[ADDR_W+1:2]; higher address bits are ignored, so the address wraps modulo 2^(ADDR_W+2).
- Misaligned access: half with DAD[0]=1, or word with DAD[1:0]≠00.
  - ERR=1 during ACK.
  - No RAM write; DDT_out=0.
- Store, committed on the ACK cycle only:
  - Byte: lane DAD[1:0] ← DDT_in[7:0].
  - Half: lanes {DAD[1],0} and {DAD[1],1} ← DDT_in[15:0].
  - Word: all lanes ← DDT_in.
  - Untouched lanes keep their value.
- Load: during ACK, DDT_oe=1 and DDT_out = word >> (8×DAD[1:0]), masked to 8/16/32 bits by SIZE. Sign extension is the core's job.
- Stores never assert DDT_oe.
- RAM contents are not affected by rst.

## Timing
- Reset values: state IDLE, ACKD_n=1, DDT_oe=0, DDT_out=0, ERR=0, counter=0.
- Request seen at edge N (MREQ=1 in IDLE) → ACKD_n low during cycle N+1+WAIT, high again from N+2+WAIT.
- ERR, DDT_oe and DDT_out are all registered and change only with ACKD_n.
- Outside ACK: ERR=0, DDT_oe=0, DDT_out=0.
- Minimum spacing between two accepted requests: WAIT+3 cycles (ACK, DONE with MREQ=0, IDLE capture).
- rst=1 in any state returns to IDLE on that edge.
  - In-flight access is aborted, with no RAM write and no ACK.
  - rst has priority over MREQ.
- Read-after-write to the same address returns the newly written data (write commits at ACK, before the next access can be captured).

## Test plan
- Reset: rst high 2 cycles with MREQ=1 → ACKD_n=1, DDT_oe=0, ERR=0 throughout; the first ACK comes WAIT+1 cycles after rst drops.
- Word store/load, WAIT=2: store 0xDEADBEEF @0x10, MREQ at edge 0 → ACKD_n low in cycle 3 only; release MREQ, then load @0x10 → DDT_out=0xDEADBEEF with DDT_oe=1 for that one cycle.
- Byte/half merge: word 0x00000000 @0x20; byte store 0xAB @0x22; half store 0x1234 @0x20 → word load returns 0x00AB1234; byte load @0x22 returns 0x000000AB; half load @0x22 returns 0x000000AB.
- Misaligned: half store @0x21 with data 0xFFFF → ERR=1 on the ACK cycle and memory unchanged (word load @0x20 still 0x00AB1234); word load @0x22 → ERR=1, DDT_out=0.
- Held request and wrap: hold MREQ=1 for 10 cycles with WAIT=0 → exactly one ACK. With ADDR_W=10, a store to 0x1000 lands at word 0, readable @0x0.
- Reset mid-access: word store 0x55 @0x40, rst pulsed during WAITST → no ACK, word @0x40 unchanged.
